// File: rtl/rtc_bus_ctrl_gen_if.sv
// Host/memory bus bundle for the RTC bus controller.
// The master side drives host requests and memory responses; the slave side is the controller.
interface rtc_bus_ctrl_gen_if #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int MW = 4
);
  logic          cs;
  logic          writestrobe;
  logic          readstrobe;
  logic [AW-1:0] dir;
  logic [DW-1:0] dato;
  logic [DW-1:0] datomem;
  logic          memorialisto;
  logic          esclisto;
  logic          actesc;
  logic          actlec;
  logic [DW-1:0] datoreg;
  logic [AW-1:0] dirreg;
  logic [MW-1:0] dirmem;
  logic [DW-1:0] datoout;
  logic          ack;
  logic          err;
  logic          busy;

  modport master (
    output cs, writestrobe, readstrobe, dir, dato, datomem, memorialisto, esclisto,
    input  actesc, actlec, datoreg, dirreg, dirmem, datoout, ack, err, busy
  );

  modport slave (
    input  cs, writestrobe, readstrobe, dir, dato, datomem, memorialisto, esclisto,
    output actesc, actlec, datoreg, dirreg, dirmem, datoout, ack, err, busy
  );
endinterface

// File: rtl/rtc_bus_ctrl_gen.sv
// RTC bus controller: latches a host access, decodes it to a memory index and runs
// the memory read/write handshake with timeout, sticky error and one-cycle ack.

module rtc_bus_ctrl_gen_chk (
  input logic clk,
  input logic reset,
  input logic actesc,
  input logic actlec,
  input logic ack,
  input logic busy
);
  a_req_exclusive: assert property (@(posedge clk) disable iff (reset) !(actesc && actlec));
  a_ack_single:    assert property (@(posedge clk) disable iff (reset) ack |=> !ack);
  a_req_busy:      assert property (@(posedge clk) disable iff (reset) (actesc || actlec) |-> busy);
endmodule

module rtc_bus_ctrl_gen #(
  parameter int            DW     = 8,
  parameter int            AW     = 8,
  parameter int            MW     = 4,
  parameter logic [AW-1:0] TBASE  = 8'h21,
  parameter int            TCNT   = 6,
  parameter logic [AW-1:0] KBASE  = 8'h41,
  parameter int            KCNT   = 3,
  parameter logic [AW-1:0] LADDR0 = 8'h0A,
  parameter logic [AW-1:0] LADDR1 = 8'h0B,
  parameter int            TMO    = 255
) (
  input logic               clk,
  input logic               reset,
  rtc_bus_ctrl_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_WREQ, S_RREQ, S_LOCAL, S_RDATA, S_HOLD, S_DONE
  } state_t;

  localparam logic [16:0] TMO_LIM = 17'(TMO);

  function automatic logic [MW-1:0] decode(input logic [AW-1:0] a);
    int ai;
    int tb;
    int kb;
    ai = int'(a);
    tb = int'(TBASE);
    kb = int'(KBASE);
    if (ai >= tb && ai < tb + TCNT) begin
      return MW'(ai - tb + 1);
    end else if (ai >= kb && ai < kb + KCNT) begin
      return MW'(ai - kb + TCNT + 1);
    end else if (a == LADDR0) begin
      return MW'(TCNT + KCNT + 1);
    end else if (a == LADDR1) begin
      return MW'(TCNT + KCNT + 2);
    end else begin
      return '0;
    end
  endfunction

  function automatic logic is_local(input logic [AW-1:0] a);
    return (a == LADDR0) || (a == LADDR1);
  endfunction

  state_t        state_r, state_s;
  logic [15:0]   cnt_r, cnt_s;
  logic          actesc_r, actlec_r;
  logic [DW-1:0] datoreg_r, datoreg_s;
  logic [AW-1:0] dirreg_r, dirreg_s;
  logic [MW-1:0] dirmem_r, dirmem_s;
  logic [DW-1:0] datoout_r, datoout_s;
  logic          ack_r, ack_s;
  logic          err_r, err_s;
  logic          busy_r;
  logic [MW-1:0] dec_s;
  logic          local_s;
  logic          timeout_s;

  // Address decode and handshake timeout detection
  always_comb begin
    dec_s     = decode(bus.dir);
    local_s   = is_local(bus.dir);
    timeout_s = (({1'b0, cnt_r} + 17'd1) == TMO_LIM);
  end

  // Next-state and next-output logic
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    datoreg_s = datoreg_r;
    dirreg_s  = dirreg_r;
    dirmem_s  = dirmem_r;
    datoout_s = datoout_r;
    ack_s     = 1'b0;
    err_s     = err_r;
    case (state_r)
      S_IDLE: begin
        if (bus.cs) begin
          state_s = S_LATCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LATCH: begin
        dirreg_s  = bus.dir;
        datoreg_s = bus.dato;
        dirmem_s  = dec_s;
        cnt_s     = 16'd0;
        // A strobe to an unmapped address fails without touching memory
        if ((bus.readstrobe || bus.writestrobe) && (dec_s == '0)) begin
          err_s     = 1'b1;
          datoout_s = '0;
          state_s   = S_DONE;
        end else if (bus.readstrobe && local_s) begin
          state_s = S_LOCAL;
        end else if (bus.readstrobe) begin
          state_s = S_RREQ;
        end else if (bus.writestrobe) begin
          state_s = S_WREQ;
        end else if (!bus.cs) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_LATCH;
        end
      end
      S_WREQ: begin
        if (bus.esclisto) begin
          ack_s     = 1'b1;
          err_s     = 1'b0;
          datoout_s = '0;
          state_s   = S_DONE;
        end else if (timeout_s) begin
          err_s     = 1'b1;
          datoout_s = '0;
          state_s   = S_DONE;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_RREQ: begin
        if (bus.memorialisto) begin
          datoout_s = bus.datomem;
          ack_s     = 1'b1;
          err_s     = 1'b0;
          state_s   = S_RDATA;
        end else if (timeout_s) begin
          err_s     = 1'b1;
          datoout_s = '0;
          state_s   = S_DONE;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      S_LOCAL: begin
        datoout_s = bus.datomem;
        ack_s     = 1'b1;
        err_s     = 1'b0;
        state_s   = S_RDATA;
      end
      S_RDATA: begin
        state_s = S_HOLD;
      end
      S_HOLD: begin
        if (!bus.cs) begin
          datoout_s = '0;
          state_s   = S_DONE;
        end else begin
          state_s = S_HOLD;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= 16'd0;
      actesc_r  <= 1'b0;
      actlec_r  <= 1'b0;
      datoreg_r <= '0;
      dirreg_r  <= '0;
      dirmem_r  <= '0;
      datoout_r <= '0;
      ack_r     <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      actesc_r  <= (state_s == S_WREQ);
      actlec_r  <= (state_s == S_RREQ);
      datoreg_r <= datoreg_s;
      dirreg_r  <= dirreg_s;
      dirmem_r  <= dirmem_s;
      datoout_r <= datoout_s;
      ack_r     <= ack_s;
      err_r     <= err_s;
      busy_r    <= (state_s != S_IDLE);
    end
  end

  assign bus.actesc  = actesc_r;
  assign bus.actlec  = actlec_r;
  assign bus.datoreg = datoreg_r;
  assign bus.dirreg  = dirreg_r;
  assign bus.dirmem  = dirmem_r;
  assign bus.datoout = datoout_r;
  assign bus.ack     = ack_r;
  assign bus.err     = err_r;
  assign bus.busy    = busy_r;

  rtc_bus_ctrl_gen_chk u_chk (
    .clk    (clk),
    .reset  (reset),
    .actesc (actesc_r),
    .actlec (actlec_r),
    .ack    (ack_r),
    .busy   (busy_r)
  );

endmodule

// File: tb/tb_rtc_bus_ctrl_gen.sv
// Randomized scoreboard bench for rtc_bus_ctrl_gen: a driver queues predicted transaction
// results, a monitor pops and compares them each time the controller returns to idle.
module tb_rtc_bus_ctrl_gen;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int MW  = 4;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rtc_bus_ctrl_gen_if #(.DW(DW), .AW(AW), .MW(MW)) bus ();

  rtc_bus_ctrl_gen #(.DW(DW), .AW(AW), .MW(MW), .TMO(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int dirmem;
    int dirreg;
    int datoreg;
    int esc;
    int lec;
    int acks;
    int dout;
    int err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tbl[256];
  int   model_err = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Memory responder: completes the d-th request cycle, otherwise random noise
  int resp_delay = 1;
  int wcnt = 0;
  int rcnt = 0;
  bit noise_en = 1'b0;
  bit late_pulse = 1'b0;
  always @(negedge clk) begin
    if (bus.actesc) begin
      wcnt++;
      bus.esclisto = (wcnt == resp_delay);
    end else begin
      wcnt = 0;
      bus.esclisto = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (bus.actlec) begin
      rcnt++;
      bus.memorialisto = (rcnt == resp_delay);
    end else begin
      rcnt = 0;
      bus.memorialisto = late_pulse | (noise_en ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  end

  // Monitor: accumulate activity per access, compare when busy drops
  int m_esc = 0, m_lec = 0, m_acks = 0, m_dout = 0, m_holdbad = 0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      m_esc = 0; m_lec = 0; m_acks = 0; m_dout = 0; m_holdbad = 0;
      prev_busy = 1'b0;
    end else begin
      if (bus.actesc) m_esc++;
      if (bus.actlec) m_lec++;
      if (m_acks > 0 && bus.busy && bus.cs && int'(bus.datoout) != m_dout) m_holdbad++;
      if (bus.ack) begin
        m_acks++;
        m_dout = int'(bus.datoout);
      end
      if (prev_busy && !bus.busy) begin
        if (q.size() == 0) begin
          chk("unexpected_access", 1, 0);
        end else begin
          e = q.pop_front();
          chk("dirmem", int'(bus.dirmem), e.dirmem);
          chk("dirreg", int'(bus.dirreg), e.dirreg);
          chk("datoreg", int'(bus.datoreg), e.datoreg);
          chk("actesc_cycles", m_esc, e.esc);
          chk("actlec_cycles", m_lec, e.lec);
          chk("ack_count", m_acks, e.acks);
          chk("datoout_at_ack", m_dout, e.dout);
          chk("err", int'(bus.err), e.err);
          chk("datoout_idle", int'(bus.datoout), 0);
          chk("datoout_hold", m_holdbad, 0);
        end
        m_esc = 0; m_lec = 0; m_acks = 0; m_dout = 0; m_holdbad = 0;
      end
      prev_busy = bus.busy;
    end
  end

  // op: 0 write, 1 read, 2 both strobes (read wins)
  task automatic txn(input int op, input int addr, input int data, input int d,
                     input int md, input int extra);
    exp_t e;
    bit   rd;
    bit   hit;
    bit   loc;
    int   n;
    rd  = (op != 0);
    hit = (tbl[addr] != 0);
    loc = (addr == 10) || (addr == 11);
    e.dirmem = tbl[addr]; e.dirreg = addr; e.datoreg = data;
    e.esc = 0; e.lec = 0; e.acks = 0; e.dout = 0;
    if (!hit) begin
      model_err = 1;
    end else if (rd && loc) begin
      e.acks = 1; e.dout = md; model_err = 0;
    end else if (d <= TMO) begin
      if (rd) e.lec = d; else e.esc = d;
      e.acks = 1;
      e.dout = rd ? md : 0;
      model_err = 0;
    end else begin
      if (rd) e.lec = TMO; else e.esc = TMO;
      model_err = 1;
    end
    e.err = model_err;
    q.push_back(e);

    @(negedge clk);
    bus.dir = AW'(addr);
    bus.dato = DW'(data);
    bus.datomem = DW'(md);
    resp_delay = d;
    bus.cs = 1'b1;
    bus.writestrobe = (op != 1);
    bus.readstrobe = (op != 0);
    repeat (2) @(negedge clk);
    bus.writestrobe = 1'b0;
    bus.readstrobe = 1'b0;
    if (rd && hit) repeat (extra) @(negedge clk);
    bus.cs = 1'b0;
    n = 0;
    while (bus.busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("busy_timeout", n, 0);
    if (!hit) chk("miss_idle_cycles", n, 1);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_actesc"}, int'(bus.actesc), 0);
    chk({tag, "_actlec"}, int'(bus.actlec), 0);
    chk({tag, "_datoreg"}, int'(bus.datoreg), 0);
    chk({tag, "_dirreg"}, int'(bus.dirreg), 0);
    chk({tag, "_dirmem"}, int'(bus.dirmem), 0);
    chk({tag, "_datoout"}, int'(bus.datoout), 0);
    chk({tag, "_ack"}, int'(bus.ack), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask

  initial begin
    int op, sel, addr;
    int acks_seen;
    for (int i = 0; i < 256; i++) tbl[i] = 0;
    for (int i = 0; i < 6; i++) tbl[33 + i] = i + 1;
    for (int i = 0; i < 3; i++) tbl[65 + i] = 7 + i;
    tbl[10] = 10;
    tbl[11] = 11;

    bus.cs = 1'b0; bus.writestrobe = 1'b0; bus.readstrobe = 1'b0;
    bus.dir = '0; bus.dato = '0; bus.datomem = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    txn(0, 8'h21, 8'h59, 3, 0, 0);
    txn(1, 8'h42, 0, 2, 8'hA5, 3);
    txn(1, 8'h0B, 0, 1, 8'h3C, 2);
    txn(0, 8'h21, 8'h11, 9, 0, 0);
    txn(0, 8'h43, 8'h77, 1, 0, 0);
    txn(1, 8'h50, 0, 1, 0, 0);
    txn(1, 8'h41, 0, TMO, 8'h5A, 1);
    txn(1, 8'h26, 0, TMO + 1, 8'h12, 0);
    txn(0, 8'h0A, 8'h33, 2, 0, 0);
    txn(2, 8'h0A, 8'h44, 1, 8'hC3, 1);

    noise_en = 1'b1;
    for (int t = 0; t < 80; t++) begin
      op  = $urandom_range(0, 2);
      sel = $urandom_range(0, 3);
      case (sel)
        0: addr = $urandom_range(0, 255);
        1: addr = 8'h21 + $urandom_range(0, 5);
        2: addr = 8'h41 + $urandom_range(0, 2);
        default: addr = 8'h0A + $urandom_range(0, 1);
      endcase
      txn(op, addr, $urandom_range(0, 255), $urandom_range(1, 6),
          $urandom_range(0, 255), $urandom_range(0, 3));
    end
    noise_en = 1'b0;

    // Reset in the middle of a memory read, then a late completion
    @(negedge clk);
    bus.dir = 8'h22;
    resp_delay = 1000;
    bus.cs = 1'b1;
    bus.readstrobe = 1'b1;
    repeat (2) @(negedge clk);
    bus.readstrobe = 1'b0;
    @(negedge clk);
    chk("pre_reset_actlec", int'(bus.actlec), 1);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    bus.cs = 1'b0;
    late_pulse = 1'b1;
    @(negedge clk);
    late_pulse = 1'b0;
    acks_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acks_seen += int'(bus.ack) + int'(bus.busy) + int'(bus.datoout != '0);
    end
    chk("late_memorialisto_ignored", acks_seen, 0);
    model_err = 0;

    txn(1, 8'h24, 0, 2, 8'h6E, 1);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rtc_bus_ctrl_gen.md
RTC_BUS_CTRL_GEN -- requirements
Module: rtc_bus_ctrl_gen

Interface
REQ-001 SHALL have parameter DW, default 8: data width of host and memory data buses.
REQ-002 SHALL have parameter AW, default 8: host address width.
REQ-003 SHALL have parameter MW, default 4: memory index width.
REQ-004 SHALL have parameter TBASE, default 8'h21, with TCNT, default 6: first address and count of the time/date register window.
REQ-005 SHALL have parameter KBASE, default 8'h41, with KCNT, default 3: first address and count of the timer register window.
REQ-006 SHALL have parameters LADDR0, default 8'h0A, and LADDR1, default 8'h0B: local (no memory cycle) addresses.
REQ-007 SHALL have parameter TMO, default 255: handshake timeout in clk cycles, range 1..65535.
REQ-008 Port list (name direction width meaning):
 clk  in  1  single clock, all logic on rising edge
 reset  in  1  synchronous, active-high
 cs  in  1  host chip select; an access spans the cs-high interval
 writestrobe  in  1  host write request
 readstrobe  in  1  host read request
 dir  in  AW  host address
 dato  in  DW  host write data
 datomem  in  DW  memory read data
 memorialisto  in  1  memory read complete
 esclisto  in  1  memory write complete
 actesc  out  1  memory write request
 actlec  out  1  memory read request
 datoreg  out  DW  latched write data
 dirreg  out  AW  latched address
 dirmem  out  MW  decoded memory index
 datoout  out  DW  host read data
 ack  out  1  one-cycle access-complete pulse
 err  out  1  sticky timeout/decode error
 busy  out  1  high in every state except IDLE

Function
REQ-009 SHALL implement states IDLE, LATCH, WREQ, RREQ, LOCAL, RDATA, HOLD, DONE.
REQ-010 IDLE: cs=1 -> LATCH; else stay.
REQ-011 LATCH: latch dir->dirreg and dato->datoreg; decode dirmem: TBASE+i -> 1+i (i<TCNT); KBASE+j -> TCNT+1+j (j<KCNT); LADDR0 -> TCNT+KCNT+1; LADDR1 -> TCNT+KCNT+2; otherwise 0.
REQ-012 LATCH next state, in priority order: readstrobe=1 and address local -> LOCAL; readstrobe=1 -> RREQ; writestrobe=1 -> WREQ; cs=0 -> IDLE; else stay and re-latch.
REQ-013 Decode miss (dirmem=0) with a strobe SHALL set err and go to DONE without a memory request.
REQ-014 WREQ: actesc=1 held until esclisto=1 is sampled, then DONE with ack=1 for one cycle.
REQ-015 RREQ: actlec=1 held until memorialisto=1 is sampled; on that edge capture datomem into datoout, then RDATA.
REQ-016 LOCAL: no request asserted; capture datomem into datoout in one cycle, then RDATA.
REQ-017 RDATA: ack=1 for exactly one cycle, then HOLD; datoout stays stable.
REQ-018 HOLD: hold datoout while cs=1; on cs=0 -> DONE.
REQ-019 DONE: clear datoout, actesc and actlec; next cycle -> IDLE; ack is never asserted in DONE except after a write (REQ-014).
REQ-020 Timeout counter SHALL clear on entry to WREQ/RREQ and increment each cycle in them; reaching TMO SHALL drop the request, set err, and go to DONE without ack.
REQ-021 err SHALL be cleared only by reset or by the next successful ack.
REQ-022 cs falling during WREQ or RREQ SHALL NOT abort the access; the access completes or times out.
REQ-023 esclisto and memorialisto seen outside WREQ and RREQ respectively SHALL be ignored.
REQ-024 Outputs SHALL be registered; request latency: strobe sampled in LATCH -> actesc/actlec high on the next cycle.

Reset
REQ-025 reset=1 at a clk edge SHALL force IDLE and zero all outputs (actesc, actlec, datoreg, dirreg, dirmem, datoout, ack, err, busy), including mid-access; a pending memory handshake is abandoned.

Verification
REQ-026 Write 8'h21 data 8'h59, esclisto after 3 cycles -> dirmem=1, datoreg=8'h59, actesc high 3 cycles, single ack, err=0.
REQ-027 Read 8'h42, memorialisto with datomem=8'hA5 after 2 cycles -> dirmem=8, datoout=8'hA5 held until cs=0, one ack.
REQ-028 Read 8'h0B -> dirmem=11, actlec never high, datoout=datomem two cycles after strobe, one ack.
REQ-029 Write 8'h21 with esclisto held low and TMO=4 -> actesc drops after 4 cycles, err=1, no ack; next good access clears err.
REQ-030 Read 8'h50 -> err=1, no request, return to IDLE within 3 cycles.
REQ-031 reset asserted while in RREQ -> all outputs 0 next cycle, state IDLE; a late memorialisto is ignored.
